// File: rtl/fixed_square.sv
// Sequential Q8.8 squarer: 16-step shift-add multiply, integer part of the square, saturated to 8 bits.
// Define FIXED_SQUARE_ROUND_EN for round-to-nearest (ties up); the default build truncates (floor).
`timescale 1ns/1ps

module fixed_square #(
    parameter int W     = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     root_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sq_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [2*W-1:0]     a;
    logic [2*W-1:0]     acc;
    logic [W-1:0]       b;
    logic [CNT_W-1:0]   cnt;

    logic [W:0]         upper;
    logic               ovf_next;
    logic [OUT_W-1:0]   sq_next;

    // Rounding adds half an LSB of the integer result; only the carry out of acc[15] matters.
    always_comb begin
        upper = {1'b0, acc[2*W-1:W]};
`ifdef FIXED_SQUARE_ROUND_EN
        upper = {1'b0, acc[2*W-1:W]} + {{W{1'b0}}, acc[W-1]};
`endif
        ovf_next = |upper[W:OUT_W];
        sq_next  = ovf_next ? {OUT_W{1'b1}} : upper[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sq_out <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a     <= {{W{1'b0}}, root_in};
                        b     <= root_in;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // After W iterations acc holds the full product; latch the result on the next edge.
                    if (cnt == LAST_CNT) begin
                        sq_out <= sq_next;
                        ovf    <= ovf_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (b[0]) begin
                            acc <= acc + a;
                        end
                        a   <= a << 1;
                        b   <= b >> 1;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_square.sv
// Self-checking bench for fixed_square: directed steps with a scoreboard queue of expected results.
// Honours FIXED_SQUARE_ROUND_EN so it can be built against either variant.
`timescale 1ns/1ps

module tb_fixed_square;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] root_in;
    logic        busy;
    logic        done;
    logic [7:0]  sq_out;
    logic        ovf;

    int          testCount = 0;
    int          failCount = 0;
    logic [8:0]  expQ[$];

    always #5 clk = ~clk;

    fixed_square dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .root_in(root_in),
        .busy(busy),
        .done(done),
        .sq_out(sq_out),
        .ovf(ovf)
    );

    // Reference: exact 32-bit product, then floor or round-half-up, then saturate.
    function automatic logic [8:0] model(input logic [15:0] r);
        logic [31:0] p;
        logic [32:0] q;
        p = 32'(r) * 32'(r);
`ifdef FIXED_SQUARE_ROUND_EN
        q = {1'b0, p} + 33'h0_0000_8000;
`else
        q = {1'b0, p};
`endif
        if (|q[32:24]) return {1'b1, 8'hFF};
        return {1'b0, q[23:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one operand for a single accepting edge; DUT must be idle.
    task automatic applyStimulus(input logic [15:0] val);
        @(negedge clk);
        root_in = val;
        start   = 1'b1;
        @(posedge clk);
        expQ.push_back(model(val));
        @(negedge clk);
        start   = 1'b0;
        root_in = ~val;
    endtask

    // Waits (bounded) for done, compares against the scoreboard, checks the pulse ends.
    task automatic checkOutput(input string tag, output int edges, output int busyCnt);
        logic [8:0] exp;
        edges   = 0;
        busyCnt = 0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyCnt++;
            if (done) break;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
            check({tag, "_queue_nonempty"}, 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                check({tag, "_result"}, {23'd0, ovf, sq_out}, {23'd0, exp});
            end
            @(posedge clk);
            #1;
            check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
            check({tag, "_busy_end"}, 32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] val;
        logic [8:0]  exp;
    } vec_t;

    initial begin
        int   edges;
        int   busyCnt;
        int   doneSeen;
        vec_t vecs[$];
        logic [15:0] rv;

        rst     = 1'b1;
        start   = 1'b0;
        root_in = 16'h0000;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", {23'd0, ovf, sq_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h0200);
        checkOutput("two", edges, busyCnt);
        check("two_latency", 32'(edges), 32'd17);
        check("two_busy_cycles", 32'(busyCnt), 32'd17);
        check("two_value", {24'd0, sq_out}, 32'd4);

        // Asynchronous reset while idle must clear outputs before any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_result", {23'd0, ovf, sq_out}, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef FIXED_SQUARE_ROUND_EN
        vecs.push_back('{16'h016A, {1'b0, 8'd2}});
        vecs.push_back('{16'h0FFC, {1'b1, 8'hFF}});
`else
        vecs.push_back('{16'h016A, {1'b0, 8'd1}});
        vecs.push_back('{16'h0FFC, {1'b0, 8'hFF}});
`endif
        vecs.push_back('{16'h1000, {1'b1, 8'hFF}});
        vecs.push_back('{16'hFFFF, {1'b1, 8'hFF}});
        vecs.push_back('{16'h0000, {1'b0, 8'd0}});
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].val);
            checkOutput($sformatf("dir_%04h", vecs[i].val), edges, busyCnt);
            check($sformatf("dir_%04h_const", vecs[i].val), {23'd0, ovf, sq_out}, {23'd0, vecs[i].exp});
            check($sformatf("dir_%04h_latency", vecs[i].val), 32'(edges), 32'd17);
        end

        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom_range(0, 16'h1100));
            applyStimulus(rv);
            checkOutput($sformatf("rand_%04h", rv), edges, busyCnt);
        end

        // Start held high during CALC is ignored, then accepted once back in IDLE.
        applyStimulus(16'h0300);
        start   = 1'b1;
        root_in = 16'h0500;
        checkOutput("hold_first", edges, busyCnt);
        check("hold_first_value", {24'd0, sq_out}, 32'd9);
        @(posedge clk);
        expQ.push_back(model(16'h0500));
        #1;
        check("hold_accept_busy", 32'(busy), 32'd1);
        check("hold_result_kept", {24'd0, sq_out}, 32'd9);
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_second", edges, busyCnt);
        check("hold_second_value", {24'd0, sq_out}, 32'd25);

        // Reset in the middle of a computation aborts it without a done pulse.
        applyStimulus(16'h0400);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_result", {23'd0, ovf, sq_out}, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        check("abort_no_done", 32'(doneSeen), 32'd0);
        applyStimulus(16'h0400);
        checkOutput("after_abort", edges, busyCnt);
        check("after_abort_value", {24'd0, sq_out}, 32'd16);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
